// File: rtl/ser_out.sv
// ser_out: start/stop framed serialiser, LSB first, DIV clocks per bit.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   en   - load request, accepted only while idle
//   in   - WIDTH-bit parallel word captured on accept
//   tx   - registered serial line, idle high
//   busy - registered, high while a frame is in flight
//   done - registered one-cycle pulse as the frame ends
module ser_out #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output logic             tx,
   output logic             busy,
   output logic             done
);
   localparam int TW = $clog2(DIV);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d, shr;
   logic [TW-1:0]    timer_q, timer_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic             tick;
   assign shr  = shift_q >> 1;
   assign tick = timer_q == T_LAST;
   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      timer_d = tick ? '0 : timer_q + TW'(1);
      bit_d   = bit_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (en) begin
               state_d = START;
               shift_d = in;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: if (tick) begin
            state_d = DATA;
            tx_d    = shift_q[0];
         end
         DATA: if (tick) begin
            if (bit_q == B_LAST) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               // next bit is presented in the same edge that shifts it into bit 0
               shift_d = shr;
               bit_d   = bit_q + BW'(1);
               tx_d    = shr[0];
            end
         end
         STOP: if (tick) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         timer_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule
